lcd_scan_gen: RTL and testbench
===============================

# lcd_scan_gen

Parametrised scan-out and video timing generator for the PocketStation LCD. It reads the LCD frame buffer through a one-clock-latency read port and upscales each LCD pixel to a SCALE×SCALE block. It emits pixel enable, sync, blanking and 8-bit grey video toward the emu top, in place of the fixed 32×32 monochrome path. Width, height, pixel depth, scale, pixel-clock divider and porch timing are all parameters.

## Interface
- H_LCD, 32, LCD pixels per row
- V_LCD, 32, LCD rows
- PIX_BITS, 1, grey bits per LCD pixel (1..4)
- SCALE, 8, screen pixels per LCD pixel, each axis (≥2)
- CE_DIV, 4, clk cycles per screen pixel (≥2)
- H_FP / H_SW / H_BP, 16 / 32 / 48, horizontal porch and sync widths in screen pixels
- V_FP / V_SW / V_BP, 8 / 4 / 20, vertical porch and sync widths in lines
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- lcd_on  in  1  LCD enable; sampled once per frame
- fb_rd  out  1  frame-buffer read strobe, one clk
- fb_addr  out  clog2(H_LCD*V_LCD)  read address = y*H_LCD + x
- fb_data  in  PIX_BITS  read data, valid exactly 1 clk after fb_rd
- ce_pix  out  1  screen-pixel enable, one clk in every CE_DIV
- hsync, vsync  out  1  active-high sync
- hblank, vblank  out  1  blanking
- grey  out  8  video intensity
- frame_start  out  1  one-clk pulse at the first pixel of each frame

## Operation
- Active area: HA = H_LCD*SCALE, VA = V_LCD*SCALE.
- Line length: HT = HA+H_FP+H_SW+H_BP.
- Frame height: VT = VA+V_FP+V_SW+V_BP.
- Order within a line: active, front porch, sync, back porch. Vertical order is the same.
- div counter runs 0..CE_DIV-1. Slot events:
  - div==0: fetch for the current (hcnt,vcnt).
  - div==CE_DIV-1: advance hcnt/vcnt.
- Position counters: hcnt 0..HT-1 and vcnt 0..VT-1.
  - hcnt wraps to 0 and increments vcnt.
  - vcnt wraps to 0 at VT.
- LCD coordinates come from sub-counters, not division. hsub/vsub count 0..SCALE-1. lx/ly increment when hsub/vsub wrap.
- Row base increments by H_LCD when ly increments. fb_addr = row base + lx.
- fb_rd: asserted at div==0 only when hcnt<HA and vcnt<VA. Exactly one read per active screen pixel.
- fb_data is captured at div==1.
- Grey mapping:
  - pixel value is bit-replicated to 8 bits then inverted, so 0 → 8'hFF and all-ones → 8'h00.
  - inactive area → 8'h00.
  - lcd_on latched 0 → active area is 8'hFF.
- lcd_on is latched when vcnt wraps to 0. A mid-frame change takes effect on the next frame.
- Reset mid-frame: all counters and outputs return to their reset values immediately. The first frame after release starts at (0,0) with frame_start.

## Timing
- ce_pix = registered (div==CE_DIV-1). It is high for 1 clk every CE_DIV clks; the first pulse comes CE_DIV clks after reset release.
- hsync, vsync, hblank, vblank, grey and frame_start are registered.
  - They update only on the edge where ce_pix is 1, and describe the pixel of the slot just ending.
  - They are stable for CE_DIV clks.
- Output latency is 1 screen pixel after the counters.
- frame_start is high for the clk after the update for (0,0), coincident with ce_pix.
- fb_addr is held stable from div==0 until the next fetch.
- Reset values: ce_pix 0, hsync 0, vsync 0, hblank 1, vblank 1, grey 0, fb_rd 0, fb_addr 0, frame_start 0, lcd_on latch 0.

## Configuration
- LCD_GRID_EN defined:
  - screen pixels with hsub==SCALE-1 or vsub==SCALE-1 inside the active area output 8'hC0, giving a visible dot-matrix grid.
  - this applies only while the latched lcd_on is 1.
- LCD_GRID_EN undefined: every screen pixel in a SCALE×SCALE block carries the LCD pixel's grey value.
- No other behaviour differs between the two.

## Test plan
- Reset: hold reset_n=0 → hblank=vblank=1, all other outputs 0. Release → first ce_pix after exactly 4 clks.
- Defaults, one frame:
  - HT=352, VT=288.
  - hsync high for 32 ce_pix per line, starting at pixel 272.
  - vsync high for 4 lines, starting at line 264.
  - exactly 65536 fb_rd pulses per frame; frame_start period 352*288*4 clks.
- Addressing: model RAM with addr-as-data.
  - lx/ly track screen position: screen (255,255) → fb_addr 1023.
  - screen (8,8) → fb_addr 33.
  - each address is repeated 8 times per line.
- Grey mapping: PIX_BITS=2, fb_data=2'b01 → grey 8'hAA. fb_data=0 → 8'hFF. Blanking → 8'h00.
- lcd_on: drop to 0 at line 100 → current frame unchanged; next frame's active area is all 8'hFF.
- Grid: with LCD_GRID_EN, fb_data=1 → grey 8'hC0 at hsub==7 or vsub==7, 8'h00 elsewhere in the block. Assert reset_n=0 mid-line → outputs back to reset values within the same clk.

Source files
------------

// File: rtl/lcd_scan_gen.sv
// lcd_scan_gen: LCD frame-buffer scan-out with SCALE upscaling and video timing; LCD_GRID_EN overlays a dot-matrix grid
module lcd_scan_gen #(
  parameter int H_LCD    = 32,
  parameter int V_LCD    = 32,
  parameter int PIX_BITS = 1,
  parameter int SCALE    = 8,
  parameter int CE_DIV   = 4,
  parameter int H_FP     = 16,
  parameter int H_SW     = 32,
  parameter int H_BP     = 48,
  parameter int V_FP     = 8,
  parameter int V_SW     = 4,
  parameter int V_BP     = 20
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             lcd_on,
  output logic                             fb_rd,
  output logic [$clog2(H_LCD*V_LCD)-1:0]   fb_addr,
  input  logic [PIX_BITS-1:0]              fb_data,
  output logic                             ce_pix,
  output logic                             hsync,
  output logic                             vsync,
  output logic                             hblank,
  output logic                             vblank,
  output logic [7:0]                       grey,
  output logic                             frame_start
);
  localparam int HA = H_LCD * SCALE;
  localparam int VA = V_LCD * SCALE;
  localparam int HT = HA + H_FP + H_SW + H_BP;
  localparam int VT = VA + V_FP + V_SW + V_BP;
  localparam int AW = $clog2(H_LCD * V_LCD);
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int SW = $clog2(SCALE);
  localparam int XW = $clog2(H_LCD);
  localparam int DW = $clog2(CE_DIV);
  localparam logic [HW-1:0] H_END = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT = HW'(HA);
  localparam logic [HW-1:0] HS0   = HW'(HA + H_FP);
  localparam logic [HW-1:0] HS1   = HW'(HA + H_FP + H_SW);
  localparam logic [VW-1:0] V_END = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT = VW'(VA);
  localparam logic [VW-1:0] VS0   = VW'(VA + V_FP);
  localparam logic [VW-1:0] VS1   = VW'(VA + V_FP + V_SW);
  localparam logic [SW-1:0] S_END = SW'(SCALE - 1);
  localparam logic [XW-1:0] X_END = XW'(H_LCD - 1);
  localparam logic [AW-1:0] R_END = AW'((V_LCD - 1) * H_LCD);
  localparam logic [AW-1:0] R_STEP = AW'(H_LCD);
  localparam logic [DW-1:0] D_END = DW'(CE_DIV - 1);
  localparam logic [DW-1:0] D_ONE = DW'(1);

  logic [DW-1:0]       div_q, div_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic [VW-1:0]       vcnt_q, vcnt_d;
  logic [SW-1:0]       hsub_q, hsub_d, vsub_q, vsub_d;
  logic [XW-1:0]       lx_q, lx_d;
  logic [AW-1:0]       row_q, row_d;
  logic [PIX_BITS-1:0] pix_q, pix_d;
  logic                lcd_q, lcd_d;
  logic                ce_pix_q, ce_pix_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic                hblank_q, hblank_d, vblank_q, vblank_d, frame_start_q, frame_start_d;
  logic [7:0]          grey_q, grey_d, rep;
  logic                adv, line_end, frame_end, h_act, v_act, act, grid;

  for (genvar i = 0; i < 8; i++) begin : g_rep
    assign rep[7-i] = pix_q[PIX_BITS-1-(i%PIX_BITS)];
  end

  always_comb begin
    adv       = div_q == D_END;
    line_end  = hcnt_q == H_END;
    frame_end = line_end && vcnt_q == V_END;
    h_act     = hcnt_q < H_ACT;
    v_act     = vcnt_q < V_ACT;
    act       = h_act && v_act;
`ifdef LCD_GRID_EN
    grid      = hsub_q == S_END || vsub_q == S_END;
`else
    grid      = 1'b0;
`endif
    div_d  = adv ? '0 : div_q + 1'b1;
    hcnt_d = !adv ? hcnt_q : line_end ? '0 : hcnt_q + 1'b1;
    hsub_d = !(adv && h_act) ? hsub_q : hsub_q == S_END ? '0 : hsub_q + 1'b1;
    lx_d   = !(adv && h_act && hsub_q == S_END) ? lx_q : lx_q == X_END ? '0 : lx_q + 1'b1;
    vcnt_d = !(adv && line_end) ? vcnt_q : frame_end ? '0 : vcnt_q + 1'b1;
    vsub_d = !(adv && line_end && v_act) ? vsub_q : vsub_q == S_END ? '0 : vsub_q + 1'b1;
    // row base steps by one LCD row whenever the vertical sub-counter wraps
    row_d  = !(adv && line_end && v_act && vsub_q == S_END) ? row_q :
             row_q == R_END ? '0 : row_q + R_STEP;
    pix_d  = div_q == D_ONE ? fb_data : pix_q;
    lcd_d  = adv && frame_end ? lcd_on : lcd_q;
    ce_pix_d      = adv;
    frame_start_d = adv && hcnt_q == '0 && vcnt_q == '0;
    hsync_d  = adv ? hcnt_q >= HS0 && hcnt_q < HS1 : hsync_q;
    vsync_d  = adv ? vcnt_q >= VS0 && vcnt_q < VS1 : vsync_q;
    hblank_d = adv ? !h_act : hblank_q;
    vblank_d = adv ? !v_act : vblank_q;
    grey_d   = !adv ? grey_q : !act ? 8'h00 : !lcd_q ? 8'hFF : grid ? 8'hC0 : ~rep;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsub_q        <= '0;
      vsub_q        <= '0;
      lx_q          <= '0;
      row_q         <= '0;
      pix_q         <= '0;
      lcd_q         <= 1'b0;
      ce_pix_q      <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      grey_q        <= 8'h00;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsub_q        <= hsub_d;
      vsub_q        <= vsub_d;
      lx_q          <= lx_d;
      row_q         <= row_d;
      pix_q         <= pix_d;
      lcd_q         <= lcd_d;
      ce_pix_q      <= ce_pix_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      grey_q        <= grey_d;
    end
  end

  // the read strobe is combinational so the first slot after release fetches, but never during reset
  assign fb_rd       = reset_n && div_q == '0 && act;
  assign fb_addr     = row_q + AW'(lx_q);
  assign ce_pix      = ce_pix_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign grey        = grey_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_lcd_scan_gen.sv
// tb_lcd_scan_gen: scoreboard bench for lcd_scan_gen on a small 4x3 LCD, 2-bit pixels, SCALE 2
module tb_lcd_scan_gen;
  localparam int HLCD = 4, VLCD = 3, SC = 2, CED = 4;
  localparam int HA = HLCD * SC, VA = VLCD * SC;
  localparam int HT = HA + 2 + 3 + 1, VT = VA + 1 + 2 + 1;

  typedef struct packed {
    logic       hs, vs, hb, vb;
    logic [7:0] g;
    logic       fs;
  } px_t;

  logic       clk = 1'b0, reset_n = 1'b0, lcd_on = 1'b1;
  logic       fb_rd, ce_pix, hsync, vsync, hblank, vblank, frame_start;
  logic [3:0] fb_addr;
  logic [1:0] fb_data = 2'b00;
  logic [7:0] grey;

  lcd_scan_gen #(
    .H_LCD(HLCD), .V_LCD(VLCD), .PIX_BITS(2), .SCALE(SC), .CE_DIV(CED),
    .H_FP(2), .H_SW(3), .H_BP(1), .V_FP(1), .V_SW(2), .V_BP(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .lcd_on(lcd_on), .fb_rd(fb_rd), .fb_addr(fb_addr),
    .fb_data(fb_data), .ce_pix(ce_pix), .hsync(hsync), .vsync(vsync), .hblank(hblank),
    .vblank(vblank), .grey(grey), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [1:0] mem [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1};
  logic [7:0] gtab [4] = '{8'hFF, 8'hAA, 8'h55, 8'h00};

  always @(posedge clk) if (fb_rd) fb_data <= mem[fb_addr];

  int  checks = 0, fails = 0, popped = 0, rd_cnt = 0, cyc = 0;
  bit  mon_en = 1'b0;
  px_t exp_q[$];
  logic [3:0] addr_q[$];
  px_t mon_e, mon_g;
  logic [3:0] mon_a;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en && ce_pix) begin
      checks++;
      popped++;
      mon_g = '{hsync, vsync, hblank, vblank, grey, frame_start};
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pixel: ce_pix with empty expected queue, got %h", mon_g);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_g !== mon_e) begin
          fails++;
          $display("FAIL pixel #%0d: got hs%b vs%b hb%b vb%b g%h fs%b, want hs%b vs%b hb%b vb%b g%h fs%b",
                   popped, mon_g.hs, mon_g.vs, mon_g.hb, mon_g.vb, mon_g.g, mon_g.fs,
                   mon_e.hs, mon_e.vs, mon_e.hb, mon_e.vb, mon_e.g, mon_e.fs);
        end
      end
    end
    if (mon_en && fb_rd) begin
      checks++;
      rd_cnt++;
      if (addr_q.size() == 0) begin
        fails++;
        $display("FAIL fb_addr: read of %0d with empty expected queue", fb_addr);
      end else begin
        mon_a = addr_q.pop_front();
        if (fb_addr !== mon_a) begin
          fails++;
          $display("FAIL fb_addr read #%0d: got %0d want %0d", rd_cnt, fb_addr, mon_a);
        end
      end
    end
  end

  task automatic push_frame(input bit lcd);
    px_t e;
    int  a;
    bit  act;
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++) begin
        act = x < HA && y < VA;
        a = (y / SC) * HLCD + x / SC;
        e.hs = x >= HA + 2 && x < HA + 5;
        e.vs = y >= VA + 1 && y < VA + 3;
        e.hb = x >= HA;
        e.vb = y >= VA;
        e.fs = x == 0 && y == 0;
        e.g  = !act ? 8'h00 : !lcd ? 8'hFF : gtab[mem[a]];
`ifdef LCD_GRID_EN
        if (act && lcd && (x % SC == SC - 1 || y % SC == SC - 1)) e.g = 8'hC0;
`endif
        exp_q.push_back(e);
        if (act) addr_q.push_back(4'(a));
      end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, int'({ce_pix, hsync, vsync, hblank, vblank, grey, fb_rd, fb_addr, frame_start}),
        int'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 1'b0}));
  endtask

  task automatic wait_fs(input string name, output int t, output int r);
    bit ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = frame_start;
    end
    #1;
    t = cyc;
    r = rd_cnt;
    if (!ok) chk({name, " timeout"}, 0, 1);
  endtask

  task automatic wait_ce(input int n);
    int seen = 0;
    for (int k = 0; k < CED * n + 100 && seen < n; k++) begin
      @(negedge clk);
      if (ce_pix) seen++;
    end
    if (seen < n) chk("wait_ce timeout", seen, n);
  endtask

  int first, t1, t2, t3, r1, r2, r3;

  initial begin
    push_frame(1'b0);
    push_frame(1'b1);
    push_frame(1'b0);
    push_frame(1'b0);
    repeat (3) @(negedge clk);
    chk_reset("reset hold");
    reset_n = 1'b1;
    mon_en  = 1'b1;
    first   = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (ce_pix && first == 0) first = k;
    end
    chk("first ce_pix clks", first, CED);
    wait_fs("frame1", t1, r1);
    wait_ce(3 * HT);
    lcd_on = 1'b0;
    wait_fs("frame2", t2, r2);
    chk("frame period clks", t2 - t1, HT * VT * CED);
    chk("reads per frame", r2 - r1, HA * VA);
    wait_fs("frame3", t3, r3);
    chk("reads frame2", r3 - r2, HA * VA);
    wait_ce(20);
    @(posedge clk);
    #1;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset("mid-line reset");
    chk("pixels checked", int'(popped >= 3 * HT * VT + 20), 1);
    repeat (2) @(negedge clk);
    chk_reset("reset held");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
